// File: rtl/posit_lzc_pipe.sv
// posit_lzc_pipe: 2-stage elastic leading-zero counter ahead of the posit normalisation shifter
module posit_lzc_pipe #(
  parameter int N = 16,
  parameter int S = 4,
  parameter int T = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [T-1:0] in_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [S-1:0] out_lzc,
  output logic         out_zero,
  output logic [T-1:0] out_tag
);
  localparam int H = N / 2;
  logic         v1, v2, ld1, ld2, zh, zl;
  logic [N-1:0] d1;
  logic [T-1:0] t1;
  logic [S-2:0] lzh, lzl;
  // Highest set bit wins; an all-zero half saturates at H-1.
  function automatic logic [S-2:0] lz_half(input logic [H-1:0] x);
    lz_half = (S-1)'(H - 1);
    for (int i = 0; i < H; i++)
      if (x[i]) lz_half = (S-1)'(H - 1 - i);
  endfunction
  assign ld2       = !v2 | out_ready;
  assign ld1       = !v1 | ld2;
  assign in_ready  = ld1;
  assign out_valid = v2;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      d1       <= '0;
      t1       <= '0;
      lzh      <= '0;
      lzl      <= '0;
      zh       <= 1'b0;
      zl       <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
      out_lzc  <= '0;
      out_zero <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld1 && in_valid) begin
        d1  <= in_data;
        t1  <= in_tag;
        lzh <= lz_half(in_data[N-1:H]);
        lzl <= lz_half(in_data[H-1:0]);
        zh  <= ~|in_data[N-1:H];
        zl  <= ~|in_data[H-1:0];
      end
      if (ld2) v2 <= v1;
      if (ld2 && v1) begin
        out_data <= d1;
        out_tag  <= t1;
        out_lzc  <= zh ? (zl ? S'(N - 1) : {1'b1, lzl}) : {1'b0, lzh};
        out_zero <= zh & zl;
      end
    end
  end
endmodule

// File: tb/tb_posit_lzc_pipe.sv
// tb_posit_lzc_pipe: directed and random scoreboard bench for posit_lzc_pipe
module tb_posit_lzc_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_zero;
  logic [15:0] in_data = 0, out_data;
  logic [7:0]  in_tag = 0, out_tag;
  logic [3:0]  out_lzc;
  logic [3:0]  e_lzc = 0;
  logic        e_zero = 0;
  logic [28:0] q[$];
  logic [28:0] held, e;
  logic [15:0] sh;
  bit          hv = 0;
  int          checks = 0, failures = 0, last_cycles = 0;

  posit_lzc_pipe #(.N(16), .S(4), .T(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lzc(out_lzc),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] clz(input logic [15:0] x);
    int n = 0;
    while (n < 15 && !x[15 - n]) n++;
    return 4'(n);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hv = 0;
    end else begin
      if (hv && out_valid) chk("stall_hold", {3'b0, out_data, out_lzc, out_zero, out_tag}, {3'b0, held});
      hv = out_valid && !out_ready;
      held = {out_data, out_lzc, out_zero, out_tag};
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("out", {3'b0, out_data, out_lzc, out_zero, out_tag}, {3'b0, e});
          if (out_data != 0) begin
            sh = out_data << out_lzc;
            chk("shift_msb", sh[15], 1);
          end
        end
      end
      if (in_valid && in_ready) q.push_back({in_data, e_lzc, e_zero, in_tag});
      if (q.size() > 2) chk("occupancy", q.size(), 2);
    end
  end

  task automatic send(input logic [15:0] d, input logic [7:0] t, input logic [3:0] l, input logic z);
    logic acc;
    int n = 0;
    in_valid = 1; in_data = d; in_tag = t; e_lzc = l; e_zero = z;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("accept_timeout", 0, 1);
    last_cycles = n;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit done;
    logic [15:0] d;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_data, out_lzc, out_zero, out_tag}, 0);
    chk("rst_in_ready", in_ready, 1);

    out_ready = 1;
    send(16'h0100, 8'h5A, 4'd7, 1'b0);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("lat_word", {out_data, out_lzc, out_zero, out_tag}, {16'h0100, 4'd7, 1'b0, 8'h5A});
    drain();

    send(16'h8000, 8'h01, 4'd0, 1'b0);  chk("b2b_ready0", last_cycles, 1);
    send(16'h0001, 8'h02, 4'd15, 1'b0); chk("b2b_ready1", last_cycles, 1);
    send(16'h0000, 8'h03, 4'd15, 1'b1); chk("b2b_ready2", last_cycles, 1);
    send(16'h0080, 8'h04, 4'd8, 1'b0);  chk("b2b_ready3", last_cycles, 1);
    drain();

    out_ready = 0;
    send(16'h0002, 8'd1, 4'd14, 1'b0);
    send(16'h0004, 8'd2, 4'd13, 1'b0);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
      begin
        send(16'h0008, 8'd3, 4'd12, 1'b0);
        send(16'h0010, 8'd4, 4'd11, 1'b0);
        send(16'h0020, 8'd5, 4'd10, 1'b0);
      end
    join
    drain();

    done = 0;
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #1;
          d = 16'($urandom) >> $urandom_range(0, 16);
          send(d, 8'(i), clz(d), d == 0);
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    drain();

    out_ready = 0;
    send(16'h1234, 8'hA1, 4'd3, 1'b0);
    send(16'h0F00, 8'hA2, 4'd4, 1'b0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    send(16'h4000, 8'hB1, 4'd1, 1'b0);
    send(16'h0003, 8'hB2, 4'd14, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
